// File: rtl/icc_branch_unit_if.sv
// Bundle between the ALU/fetch/decode pipeline and the icc branch unit.
// master = pipeline side, slave = icc_branch_unit.
interface icc_branch_unit_if;
    logic       alu_valid;
    logic [5:0] alu_opcode;
    logic       alu_n;
    logic       alu_z;
    logic       alu_v;
    logic       alu_c;
    logic       psr_we;
    logic [3:0] psr_wdata;
    logic       carry_o;
    logic [3:0] icc_o;
    logic       br_valid;
    logic [3:0] br_cond;
    logic       br_annul;
    logic       instr_valid;
    logic       br_taken;
    logic       squash_o;
    logic       dcti_err;

    modport master (
        output alu_valid, alu_opcode, alu_n, alu_z, alu_v, alu_c,
        output psr_we, psr_wdata,
        output br_valid, br_cond, br_annul, instr_valid,
        input  carry_o, icc_o, br_taken, squash_o, dcti_err
    );

    modport slave (
        input  alu_valid, alu_opcode, alu_n, alu_z, alu_v, alu_c,
        input  psr_we, psr_wdata,
        input  br_valid, br_cond, br_annul, instr_valid,
        output carry_o, icc_o, br_taken, squash_o, dcti_err
    );
endinterface

// File: rtl/icc_branch_unit.sv
// Integer condition codes {N,Z,V,C}, Bicc condition evaluation and the
// delay-slot / annul sequencer feeding fetch and decode.
module icc_branch_unit #(
    parameter logic [3:0] RESET_ICC = 4'b0000
) (
    input logic             clk,
    input logic             rst_n,
    icc_branch_unit_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DSLOT = 1'b1;

    localparam logic [3:0] COND_BN = 4'b0000;
    localparam logic [3:0] COND_BA = 4'b1000;

    logic [3:0] icc_q,      icc_d;
    logic [0:0] state_q,    state_d;
    logic       annul_q,    annul_d;
    logic       br_taken_q, br_taken_d;
    logic       dcti_err_q, dcti_err_d;
    logic       cond_true;
    logic       unused_opcode_bits;

    // cond[3] inverts the sense of the base test selected by cond[2:0].
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] icc);
        logic n, z, v, c, base;
        n = icc[3];
        z = icc[2];
        v = icc[1];
        c = icc[0];
        unique case (cond[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = z;
            3'd2:    base = z | (n ^ v);
            3'd3:    base = n ^ v;
            3'd4:    base = c | z;
            3'd5:    base = c;
            3'd6:    base = n;
            default: base = v;
        endcase
        return base ^ cond[3];
    endfunction

    assign unused_opcode_bits = &{1'b0, bus.alu_opcode[3:2]};

    always_comb begin
        icc_d = icc_q;
        if (bus.psr_we) begin
            icc_d = bus.psr_wdata;
        end else if (bus.alu_valid && !bus.alu_opcode[5] && bus.alu_opcode[4]) begin
            if (bus.alu_opcode[1:0] == 2'b00)
                icc_d = {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};
            else
                icc_d = {bus.alu_n, bus.alu_z, 2'b00};
        end
    end

    // Branches see icc_d so a same-cycle flag write is forwarded.
    assign cond_true = cond_eval(bus.br_cond, icc_d);

    always_comb begin
        state_d    = state_q;
        annul_d    = annul_q;
        br_taken_d = 1'b0;
        dcti_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.br_valid) begin
                    br_taken_d = cond_true;
                    annul_d    = bus.br_annul &
                                 ((bus.br_cond == COND_BA) || (bus.br_cond == COND_BN) || !cond_true);
                    state_d    = ST_DSLOT;
                end
            end
            default: begin
                if (bus.instr_valid || bus.br_valid) begin
                    dcti_err_d = bus.br_valid & ~annul_q;
                    annul_d    = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icc_q      <= RESET_ICC;
            state_q    <= ST_IDLE;
            annul_q    <= 1'b0;
            br_taken_q <= 1'b0;
            dcti_err_q <= 1'b0;
        end else begin
            icc_q      <= icc_d;
            state_q    <= state_d;
            annul_q    <= annul_d;
            br_taken_q <= br_taken_d;
            dcti_err_q <= dcti_err_d;
        end
    end

    assign bus.icc_o    = icc_q;
    assign bus.carry_o  = icc_q[0];
    assign bus.br_taken = br_taken_q;
    assign bus.dcti_err = dcti_err_q;
    assign bus.squash_o = (state_q == ST_DSLOT) & annul_q & (bus.instr_valid | bus.br_valid);

endmodule

// File: doc/icc_branch_unit.md
Name: icc_branch_unit

Overview:
- Holds the integer condition codes (icc: N, Z, V, C) produced by the 32-bit ALU.
- Returns the stored carry to the ALU for ADDX/SUBX.
- Evaluates SPARC Bicc conditions and runs the delay-slot/annul sequence.
- Sits between the ALU flag outputs and fetch/decode, which consume the taken and squash decisions.

Parameters:
- RESET_ICC, 4'b0000, reset value of {N,Z,V,C}.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result and flags are valid this cycle.
- alu_opcode  in  6  opcode of the ALU operation producing the flags.
- alu_n, alu_z, alu_v, alu_c  in  1 each  ALU flag outputs.
- psr_we  in  1  direct icc write (WRPSR path).
- psr_wdata  in  4  {N,Z,V,C} for the direct write.
- carry_o  out  1  registered C, fed to the ALU carry input.
- icc_o  out  4  registered {N,Z,V,C}.
- br_valid  in  1  Bicc instruction presented this cycle.
- br_cond  in  4  Bicc cond field.
- br_annul  in  1  Bicc a-bit.
- instr_valid  in  1  a non-branch instruction issues this cycle; used to consume the delay slot.
- br_taken  out  1  registered; 1-cycle pulse, branch taken.
- squash_o  out  1  combinational; the current delay-slot instruction must be annulled.
- dcti_err  out  1  registered; 1-cycle pulse, branch issued inside an unsquashed delay slot.

Behaviour:
- Reset (async, rst_n=0):
  - icc = RESET_ICC, state = IDLE.
  - br_taken = 0, dcti_err = 0, annul_pending = 0.
  - squash_o = 0 and carry_o = RESET_ICC[0], derived from state and icc.
  - Reset mid-sequence abandons any pending delay slot.
- icc write rules (next-state, applied at the clock edge):
  - psr_we=1: icc <= psr_wdata. This has priority over any simultaneous ALU write.
  - Otherwise, with alu_valid=1, opcode[5]=0 and opcode[4]=1 (S-bit):
    - opcode[1:0]=00 (add/addx/sub/subx): icc <= {alu_n, alu_z, alu_v, alu_c}.
    - opcode[1:0]!=00 (logic): N, Z take the ALU values; V <= 0; C <= 0.
  - Shift opcodes (opcode[5]=1), non-S opcodes and alu_valid=0 leave icc unchanged.
- Forwarding:
  - A branch evaluates against the icc next-value. A same-cycle flag write is visible to that branch.
- Condition table (cond: expression):
  - 0000 BN: 0; 1000 BA: 1.
  - 0001 BE: Z; 1001 BNE: ~Z.
  - 0010 BLE: Z|(N^V); 1010 BG: ~(Z|(N^V)).
  - 0011 BL: N^V; 1011 BGE: ~(N^V).
  - 0100 BLEU: C|Z; 1100 BGU: ~(C|Z).
  - 0101 BCS: C; 1101 BCC: ~C.
  - 0110 BNEG: N; 1110 BPOS: ~N.
  - 0111 BVS: V; 1111 BVC: ~V.
- Annul decision, annul_pending <= br_annul & (cond==BA | cond==BN | ~taken):
  - BA,a: delay slot annulled.
  - BN,a: delay slot annulled.
  - Conditional not taken with a=1: delay slot annulled.
  - Conditional taken with a=1: delay slot executes.
  - a=0: delay slot never annulled.
- State machine, states IDLE and DSLOT:
  - IDLE, br_valid=1: register br_taken (pulse next cycle), latch annul_pending, go to DSLOT.
  - DSLOT, instr_valid=1 or br_valid=1: the slot is consumed; return to IDLE.
  - squash_o = (state==DSLOT) & annul_pending & (instr_valid|br_valid).
  - DSLOT, br_valid=1 while annul_pending=1: the branch is squashed and ignored; no br_taken, no dcti_err.
  - DSLOT, br_valid=1 while annul_pending=0: the branch is ignored and dcti_err pulses next cycle.
  - DSLOT with neither valid (bubble): stay in DSLOT, squash_o=0.
- Flag writes during DSLOT:
  - The ALU does not gate on squash_o, so the pipeline must not assert alu_valid for a squashed slot.
  - This block applies any flag write it receives.
- Latency:
  - icc_o and carry_o update 1 cycle after the write.
  - br_taken rises 1 cycle after br_valid.
  - squash_o is same-cycle with the delay-slot instruction.
- Simultaneous br_valid and instr_valid in IDLE: br_valid wins; instr_valid is ignored by this block.

Test Plan:
- Reset with RESET_ICC=4'b0101, then release -> icc_o=0101, carry_o=1, br_taken=0, squash_o=0.
- alu_opcode=010000, flags N=1,Z=0,V=1,C=1, alu_valid=1 -> next cycle icc_o=1011. Then opcode 010001, flags N=0,Z=1 -> icc_o=0100 (V, C cleared). Then opcode 100111 -> icc unchanged.
- Same cycle: alu S-write giving Z=1 and br_valid with cond=0001 (BE) -> br_taken=1 next cycle (forwarding). Same cycle psr_we=1, psr_wdata=0000 with an ALU write -> icc_o=0000.
- BA with a=1 -> br_taken=1; next instr_valid gives squash_o=1. BNE not taken with a=1 -> squash_o=1. BNE taken with a=1 -> squash_o=0. BL with a=0 -> squash_o=0.
- Branch with a=0, then br_valid in the delay slot -> dcti_err pulses 1 cycle, no second br_taken. Branch with annulled slot, then br_valid in the slot -> squash_o=1, no dcti_err.
- Branch accepted, two bubble cycles, then rst_n=0 -> state IDLE; the next instr_valid gives squash_o=0.
